// File: rtl/mpmc11_pkg.sv
// Shared mpmc11 controller types: controller state, write-pair slot and fill-FSM encoding.
// Pure type/constant package; no logic, no latency, no flow control.
// Pair width follows MPMC11_WID; blocks using mpmc11_wrpair_t must run at that width.
package mpmc11_pkg;

  localparam int MPMC11_WID  = 256;
  localparam int MPMC11_SELW = MPMC11_WID / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    PRESET1,
    PRESET2,
    PRESET3,
    ST_WRITE,
    ST_READ
  } mpmc11_state_t;

  typedef struct packed {
    logic [MPMC11_WID-1:0]  d0;
    logic [MPMC11_WID-1:0]  d1;
    logic [MPMC11_SELW-1:0] s0;
    logic [MPMC11_SELW-1:0] s1;
  } mpmc11_wrpair_t;

  typedef enum logic {
    WRF_BEAT0,
    WRF_BEAT1
  } mpmc11_wrfill_t;

endpackage

// File: rtl/mpmc11_wrdata_mask.sv
// Zeroes every data byte whose select bit is clear.
// Purely combinational, zero latency; no flow control.
// Only instantiated when MPMC11_WRBUF_MASK_ZERO_EN is defined.
module mpmc11_wrdata_mask #(
  parameter int WID  = 256,
  parameter int SELW = WID / 8
) (
  input  logic [WID-1:0]  data,
  input  logic [SELW-1:0] sel,
  output logic [WID-1:0]  masked
);

  always_comb begin
    masked = '0;
    for (int i = 0; i < SELW; i++) begin
      masked[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/mpmc11_wrdata_pair_buf.sv
// Packs write beats into two-beat pairs, double-buffered; head pair retires on PRESET3.
// Zero-cycle head latency from the slot registers; a pair completed at edge N is retirable at N+1.
// s_ready drops while both slots are full. MPMC11_WRBUF_MASK_ZERO_EN zeroes unselected bytes.
module mpmc11_wrdata_pair_buf
  import mpmc11_pkg::*;
#(
  parameter int WID  = 256,
  parameter int SELW = WID / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  mpmc11_state_t   state,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [WID-1:0]  s_data,
  input  logic [SELW-1:0] s_sel,
  input  logic            s_last,
  output logic            pair_valid,
  output logic [WID-1:0]  dato1,
  output logic [WID-1:0]  dato2,
  output logic [SELW-1:0] selo1,
  output logic [SELW-1:0] selo2,
  output logic            underrun
);

  mpmc11_wrpair_t slot [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;
  mpmc11_wrfill_t fill;
  logic           underrun_q;
  logic [WID-1:0] beat_data;

`ifdef MPMC11_WRBUF_MASK_ZERO_EN
  mpmc11_wrdata_mask #(.WID(WID), .SELW(SELW)) u_mask (
    .data   (s_data),
    .sel    (s_sel),
    .masked (beat_data)
  );
`else
  assign beat_data = s_data;
`endif

  logic accept;
  logic complete;
  logic retire;

  assign s_ready  = (count < 2'd2);
  assign accept   = s_valid && s_ready;
  assign complete = accept && ((fill == WRF_BEAT1) || s_last);
  assign retire   = (state == PRESET3) && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) slot[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      fill       <= WRF_BEAT0;
      underrun_q <= 1'b0;
    end else begin
      if (accept) begin
        if (fill == WRF_BEAT0) begin
          slot[wr_ptr].d0 <= beat_data;
          slot[wr_ptr].s0 <= s_sel;
          if (s_last) begin
            // Single-beat burst: the empty second half must not leak an older pair.
            slot[wr_ptr].d1 <= '0;
            slot[wr_ptr].s1 <= '0;
          end else begin
            fill <= WRF_BEAT1;
          end
        end else begin
          slot[wr_ptr].d1 <= beat_data;
          slot[wr_ptr].s1 <= s_sel;
          fill            <= WRF_BEAT0;
        end
      end
      if (complete) wr_ptr <= ~wr_ptr;
      if (retire)   rd_ptr <= ~rd_ptr;
      case ({complete, retire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if ((state == PRESET3) && (count == 2'd0)) underrun_q <= 1'b1;
    end
  end

  assign pair_valid = (count != 2'd0);
  assign dato1      = slot[rd_ptr].d0;
  assign dato2      = slot[rd_ptr].d1;
  assign selo1      = slot[rd_ptr].s0;
  assign selo2      = slot[rd_ptr].s1;
  assign underrun   = underrun_q;

endmodule
